block_device_requester: RTL and testbench

Initiator for the block-device request/data/response protocol. It accepts one sector-range command at a time from a local controller and bounds-checks it against the device info. It issues the device request, streams write data to the device or read data from it, and reports completion with a status. It sits between a DMA/controller front end and the block-device port of the simulated or real device.

---
 rtl/bdev_pkg.sv | 20 ++
 rtl/block_device_requester.sv | 172 +++++++++++++++++
 tb/tb_block_device_requester.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bdev_pkg.sv
// Shared definitions for the block-device request/data/response protocol:
// field widths, data beats per sector, and the requester state encoding.
package bdev_pkg;

   localparam int BDEV_ADDR_BITS        = 32;
   localparam int BDEV_SECTOR_BITS      = BDEV_ADDR_BITS;
   localparam int BDEV_DATA_BITS        = 64;
   localparam int BDEV_TAG_BITS         = 1;
   localparam int BDEV_BEATS_PER_SECTOR = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WDATA,
      ST_WACK,
      ST_RDATA,
      ST_DONE
   } bdev_state_t;

endpackage

// File: rtl/block_device_requester.sv
// Block-device initiator: bounds-checks one sector-range command, issues the
// request, passes data through with zero latency and reports a status.
module block_device_requester
   import bdev_pkg::*;
#(
   parameter int DATA_BITS        = BDEV_DATA_BITS,
   parameter int SECTOR_BITS      = BDEV_SECTOR_BITS,
   parameter int TAG_BITS         = BDEV_TAG_BITS,
   parameter int BEATS_PER_SECTOR = BDEV_BEATS_PER_SECTOR
) (
   input  logic                   clock,
   input  logic                   reset,

   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [SECTOR_BITS-1:0] cmd_offset,
   input  logic [SECTOR_BITS-1:0] cmd_len,
   input  logic [TAG_BITS-1:0]    cmd_tag,

   input  logic                   wdata_valid,
   output logic                   wdata_ready,
   input  logic [DATA_BITS-1:0]   wdata_bits,

   output logic                   rdata_valid,
   input  logic                   rdata_ready,
   output logic [DATA_BITS-1:0]   rdata_bits,

   output logic                   done_valid,
   input  logic                   done_ready,
   output logic                   done_err,

   output logic                   bdev_req_valid,
   input  logic                   bdev_req_ready,
   output logic                   bdev_req_bits_write,
   output logic [SECTOR_BITS-1:0] bdev_req_bits_offset,
   output logic [SECTOR_BITS-1:0] bdev_req_bits_len,
   output logic [TAG_BITS-1:0]    bdev_req_bits_tag,

   output logic                   bdev_data_valid,
   input  logic                   bdev_data_ready,
   output logic [DATA_BITS-1:0]   bdev_data_bits_data,
   output logic [TAG_BITS-1:0]    bdev_data_bits_tag,

   input  logic                   bdev_resp_valid,
   output logic                   bdev_resp_ready,
   input  logic [DATA_BITS-1:0]   bdev_resp_bits_data,
   input  logic [TAG_BITS-1:0]    bdev_resp_bits_tag,

   input  logic [SECTOR_BITS-1:0] bdev_info_nsectors,
   input  logic [SECTOR_BITS-1:0] bdev_info_max_req_len
);

   localparam int BEAT_SHIFT = $clog2(BEATS_PER_SECTOR);
   localparam int CNT_BITS   = SECTOR_BITS + BEAT_SHIFT;

   bdev_state_t          state;
   logic [CNT_BITS-1:0]  beat_cnt;
   logic                 reject;
   logic                 mismatch;

   logic [SECTOR_BITS:0] cmd_end;
   logic                 cmd_err;
   logic                 wdata_fire;
   logic                 resp_fire;
   logic                 resp_tag_bad;
   logic                 last_beat;

   // One extra bit keeps offset+len from wrapping past the device size.
   assign cmd_end = {1'b0, cmd_offset} + {1'b0, cmd_len};
   assign cmd_err = (cmd_len == '0) || (cmd_len > bdev_info_max_req_len) ||
                    (cmd_end > {1'b0, bdev_info_nsectors});

   assign bdev_data_valid     = (state == ST_WDATA) && wdata_valid;
   assign wdata_ready         = (state == ST_WDATA) && bdev_data_ready;
   assign bdev_data_bits_data = (state == ST_WDATA) ? wdata_bits : '0;
   assign bdev_data_bits_tag  = (state == ST_WDATA) ? bdev_req_bits_tag : '0;

   assign rdata_valid     = (state == ST_RDATA) && bdev_resp_valid;
   assign rdata_bits      = (state == ST_RDATA) ? bdev_resp_bits_data : '0;
   assign bdev_resp_ready = (state == ST_WACK) || ((state == ST_RDATA) && rdata_ready);

   assign wdata_fire   = bdev_data_valid && bdev_data_ready;
   assign resp_fire    = bdev_resp_valid && bdev_resp_ready;
   assign resp_tag_bad = (bdev_resp_bits_tag != bdev_req_bits_tag);
   assign last_beat    = (beat_cnt == CNT_BITS'(1));

   // NOTE: every register here is updated with <= so all of them see the
   // pre-edge values of each other, whatever order the branches are written in.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                <= ST_IDLE;
         beat_cnt             <= '0;
         reject               <= 1'b0;
         mismatch             <= 1'b0;
         cmd_ready            <= 1'b0;
         done_valid           <= 1'b0;
         done_err             <= 1'b0;
         bdev_req_valid       <= 1'b0;
         bdev_req_bits_write  <= 1'b0;
         bdev_req_bits_offset <= '0;
         bdev_req_bits_len    <= '0;
         bdev_req_bits_tag    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready            <= 1'b0;
                  bdev_req_bits_write  <= cmd_write;
                  bdev_req_bits_offset <= cmd_offset;
                  bdev_req_bits_len    <= cmd_len;
                  bdev_req_bits_tag    <= cmd_tag;
                  if (cmd_err) begin
                     reject     <= 1'b1;
                     done_valid <= 1'b1;
                     done_err   <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     bdev_req_valid <= 1'b1;
                     state          <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (bdev_req_ready) begin
                  bdev_req_valid <= 1'b0;
                  beat_cnt       <= CNT_BITS'(bdev_req_bits_len) << BEAT_SHIFT;
                  state          <= bdev_req_bits_write ? ST_WDATA : ST_RDATA;
               end
            end
            ST_WDATA: begin
               if (wdata_fire) begin
                  beat_cnt <= beat_cnt - 1'b1;
                  if (last_beat) state <= ST_WACK;
               end
            end
            ST_WACK: begin
               if (resp_fire) begin
                  mismatch   <= mismatch || resp_tag_bad;
                  done_valid <= 1'b1;
                  done_err   <= reject || mismatch || resp_tag_bad;
                  state      <= ST_DONE;
               end
            end
            ST_RDATA: begin
               if (resp_fire) begin
                  mismatch <= mismatch || resp_tag_bad;
                  beat_cnt <= beat_cnt - 1'b1;
                  if (last_beat) begin
                     done_valid <= 1'b1;
                     done_err   <= reject || mismatch || resp_tag_bad;
                     state      <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (done_ready) begin
                  done_valid <= 1'b0;
                  done_err   <= 1'b0;
                  reject     <= 1'b0;
                  mismatch   <= 1'b0;
                  cmd_ready  <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_block_device_requester.sv
// Directed bench for block_device_requester: the bench plays both the
// controller and the device, stepping one clock at a time.
module tb_block_device_requester;

   logic        clock = 1'b0;
   logic        reset = 1'b0;

   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [31:0] cmd_offset = '0, cmd_len = '0;
   logic [0:0]  cmd_tag = '0;
   logic        wdata_valid = 1'b0, wdata_ready;
   logic [63:0] wdata_bits = '0;
   logic        rdata_valid, rdata_ready = 1'b0;
   logic [63:0] rdata_bits;
   logic        done_valid, done_ready = 1'b0, done_err;
   logic        bdev_req_valid, bdev_req_ready = 1'b0, bdev_req_bits_write;
   logic [31:0] bdev_req_bits_offset, bdev_req_bits_len;
   logic [0:0]  bdev_req_bits_tag;
   logic        bdev_data_valid, bdev_data_ready = 1'b0;
   logic [63:0] bdev_data_bits_data;
   logic [0:0]  bdev_data_bits_tag;
   logic        bdev_resp_valid = 1'b0, bdev_resp_ready;
   logic [63:0] bdev_resp_bits_data = '0;
   logic [0:0]  bdev_resp_bits_tag = '0;
   logic [31:0] bdev_info_nsectors = 32'd16, bdev_info_max_req_len = 32'd8;

   int errors = 0;
   int checks = 0;
   int beats;
   logic hs;

   block_device_requester dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_offset(cmd_offset), .cmd_len(cmd_len), .cmd_tag(cmd_tag),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata_bits(wdata_bits),
      .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata_bits(rdata_bits),
      .done_valid(done_valid), .done_ready(done_ready), .done_err(done_err),
      .bdev_req_valid(bdev_req_valid), .bdev_req_ready(bdev_req_ready),
      .bdev_req_bits_write(bdev_req_bits_write), .bdev_req_bits_offset(bdev_req_bits_offset),
      .bdev_req_bits_len(bdev_req_bits_len), .bdev_req_bits_tag(bdev_req_bits_tag),
      .bdev_data_valid(bdev_data_valid), .bdev_data_ready(bdev_data_ready),
      .bdev_data_bits_data(bdev_data_bits_data), .bdev_data_bits_tag(bdev_data_bits_tag),
      .bdev_resp_valid(bdev_resp_valid), .bdev_resp_ready(bdev_resp_ready),
      .bdev_resp_bits_data(bdev_resp_bits_data), .bdev_resp_bits_tag(bdev_resp_bits_tag),
      .bdev_info_nsectors(bdev_info_nsectors), .bdev_info_max_req_len(bdev_info_max_req_len)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue_cmd(input logic wr, input logic [31:0] off, input logic [31:0] len,
                            input logic [0:0] tag);
      check("cmd_ready_before_cmd", cmd_ready, 1'b1);
      cmd_valid  = 1'b1;
      cmd_write  = wr;
      cmd_offset = off;
      cmd_len    = len;
      cmd_tag    = tag;
      step();
      cmd_valid = 1'b0;
      check("cmd_ready_after_accept", cmd_ready, 1'b0);
   endtask

   task automatic accept_req(input logic wr, input logic [31:0] off, input logic [31:0] len,
                             input logic [0:0] tag);
      check("req_valid", bdev_req_valid, 1'b1);
      check("req_write", bdev_req_bits_write, wr);
      check("req_offset", bdev_req_bits_offset, off);
      check("req_len", bdev_req_bits_len, len);
      check("req_tag", bdev_req_bits_tag, tag);
      bdev_req_ready = 1'b1;
      step();
      bdev_req_ready = 1'b0;
      check("req_valid_after_hs", bdev_req_valid, 1'b0);
   endtask

   task automatic read_sector(input logic [63:0] base, input logic [0:0] tag, input int bad_beat);
      for (int i = 0; i < 64; i++) begin
         bdev_resp_valid     = 1'b1;
         bdev_resp_bits_data = base + 64'(i);
         bdev_resp_bits_tag  = (i == bad_beat) ? ~tag : tag;
         rdata_ready         = 1'b1;
         #1;
         check("rd_valid", rdata_valid, 1'b1);
         check("rd_bits", rdata_bits, base + 64'(i));
         check("rd_resp_ready", bdev_resp_ready, 1'b1);
         check("rd_no_early_done", done_valid, 1'b0);
         step();
      end
      bdev_resp_valid = 1'b0;
      rdata_ready     = 1'b0;
   endtask

   task automatic finish_done(input logic exp_err);
      check("done_valid", done_valid, 1'b1);
      check("done_err", done_err, exp_err);
      check("cmd_ready_in_done", cmd_ready, 1'b0);
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
      check("done_valid_cleared", done_valid, 1'b0);
      check("cmd_ready_returns", cmd_ready, 1'b1);
   endtask

   initial begin
      // Reset state, observed before any clock edge.
      #1 reset = 1'b1;
      #2;
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_req_valid", bdev_req_valid, 1'b0);
      check("rst_done_valid", done_valid, 1'b0);
      check("rst_done_err", done_err, 1'b0);
      check("rst_req_offset", bdev_req_bits_offset, 32'd0);
      check("rst_req_len", bdev_req_bits_len, 32'd0);
      check("rst_resp_ready", bdev_resp_ready, 1'b0);
      repeat (2) @(posedge clock);
      #4 reset = 1'b0;
      step();
      check("cmd_ready_after_reset", cmd_ready, 1'b1);

      // Read offset=4 len=1, request held one cycle by the device.
      issue_cmd(1'b0, 32'd4, 32'd1, 1'b0);
      check("req_hold_valid", bdev_req_valid, 1'b1);
      step();
      accept_req(1'b0, 32'd4, 32'd1, 1'b0);
      read_sector(64'hA000, 1'b0, -1);
      finish_done(1'b0);

      // Write offset=0 len=2 tag=1 with source gaps and a 10-cycle device stall.
      issue_cmd(1'b1, 32'd0, 32'd2, 1'b1);
      accept_req(1'b1, 32'd0, 32'd2, 1'b1);
      beats = 0;
      for (int cyc = 0; cyc < 400 && beats < 128; cyc++) begin
         wdata_valid     = (cyc % 3) != 2;
         bdev_data_ready = !(cyc >= 40 && cyc < 50);
         wdata_bits      = 64'hB000 + 64'(beats);
         #1;
         check("wr_fwd_valid", bdev_data_valid, wdata_valid);
         check("wr_fwd_ready", wdata_ready, bdev_data_ready);
         check("wr_no_ack_yet", bdev_resp_ready, 1'b0);
         if (wdata_valid) begin
            check("wr_data", bdev_data_bits_data, 64'hB000 + 64'(beats));
            check("wr_tag", bdev_data_bits_tag, 1'b1);
         end
         hs = wdata_valid && bdev_data_ready;
         step();
         if (hs) beats++;
      end
      check("wr_beat_count", beats, 128);
      wdata_valid     = 1'b1;
      bdev_data_ready = 1'b1;
      #1;
      check("wack_wdata_ready", wdata_ready, 1'b0);
      check("wack_data_valid", bdev_data_valid, 1'b0);
      check("wack_resp_ready", bdev_resp_ready, 1'b1);
      bdev_resp_valid    = 1'b1;
      bdev_resp_bits_tag = 1'b1;
      step();
      bdev_resp_valid = 1'b0;
      wdata_valid     = 1'b0;
      bdev_data_ready = 1'b0;
      finish_done(1'b0);

      // Rejects: zero length, over max_req_len, past end of device.
      issue_cmd(1'b0, 32'd0, 32'd0, 1'b0);
      check("rej0_req_valid", bdev_req_valid, 1'b0);
      finish_done(1'b1);
      issue_cmd(1'b0, 32'd0, 32'd9, 1'b0);
      check("rej_max_req_valid", bdev_req_valid, 1'b0);
      finish_done(1'b1);
      issue_cmd(1'b1, 32'd15, 32'd2, 1'b0);
      check("rej_end_req_valid", bdev_req_valid, 1'b0);
      finish_done(1'b1);

      // Tag mismatch on beat 10; all beats still forwarded.
      issue_cmd(1'b0, 32'd0, 32'd1, 1'b1);
      accept_req(1'b0, 32'd0, 32'd1, 1'b1);
      read_sector(64'hD000, 1'b1, 10);
      finish_done(1'b1);

      // Backpressure: rdata_ready low for 20 cycles, then done_ready low for 5.
      issue_cmd(1'b0, 32'd2, 32'd1, 1'b0);
      accept_req(1'b0, 32'd2, 32'd1, 1'b0);
      beats = 0;
      for (int cyc = 0; cyc < 200 && beats < 64; cyc++) begin
         rdata_ready         = !(cyc >= 20 && cyc < 40);
         bdev_resp_valid     = 1'b1;
         bdev_resp_bits_data = 64'hC000 + 64'(beats);
         bdev_resp_bits_tag  = 1'b0;
         #1;
         check("bp_resp_ready", bdev_resp_ready, rdata_ready);
         check("bp_rd_valid", rdata_valid, 1'b1);
         check("bp_rd_bits", rdata_bits, 64'hC000 + 64'(beats));
         hs = rdata_ready;
         step();
         if (hs) beats++;
      end
      check("bp_beat_count", beats, 64);
      bdev_resp_valid = 1'b0;
      rdata_ready     = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_done_hold", done_valid, 1'b1);
         check("bp_cmd_ready_low", cmd_ready, 1'b0);
         step();
      end
      finish_done(1'b0);

      // Async reset in the middle of a write, at beat 30.
      issue_cmd(1'b1, 32'd1, 32'd1, 1'b0);
      accept_req(1'b1, 32'd1, 32'd1, 1'b0);
      wdata_valid     = 1'b1;
      bdev_data_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         wdata_bits = 64'hE000 + 64'(i);
         #1;
         check("rst_wr_data", bdev_data_bits_data, 64'hE000 + 64'(i));
         step();
      end
      bdev_resp_valid = 1'b1;
      rdata_ready     = 1'b1;
      #1;
      check("pre_rst_data_valid", bdev_data_valid, 1'b1);
      reset = 1'b1;
      #1;
      check("mid_rst_data_valid", bdev_data_valid, 1'b0);
      check("mid_rst_wdata_ready", wdata_ready, 1'b0);
      check("mid_rst_resp_ready", bdev_resp_ready, 1'b0);
      check("mid_rst_rdata_valid", rdata_valid, 1'b0);
      check("mid_rst_done_valid", done_valid, 1'b0);
      check("mid_rst_cmd_ready", cmd_ready, 1'b0);
      check("mid_rst_req_len", bdev_req_bits_len, 32'd0);
      #2 reset = 1'b0;
      wdata_valid     = 1'b0;
      bdev_data_ready = 1'b0;
      bdev_resp_valid = 1'b0;
      rdata_ready     = 1'b0;
      step();
      check("post_rst_done_valid", done_valid, 1'b0);
      issue_cmd(1'b0, 32'd7, 32'd1, 1'b0);
      accept_req(1'b0, 32'd7, 32'd1, 1'b0);
      read_sector(64'hF000, 1'b0, -1);
      finish_done(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
